// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the fetch stage: next-PC select encodings, bubble encoding,
// FSM state constants and the redirect target selector.
package if_fetch_stage_pkg;

    localparam logic [1:0] NPC_BEQ = 2'd0;
    localparam logic [1:0] NPC_JR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;

    localparam logic [31:0] NOP_ENC = 32'h0000_0000;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Select 3 is reserved and falls back to the branch target.
    function automatic logic [31:0] sel_target(
        input logic [1:0]  sel,
        input logic [31:0] beq_addr,
        input logic [31:0] jr_addr,
        input logic [31:0] j_addr
    );
        logic [31:0] t;
        case (sel)
            NPC_BEQ: t = beq_addr;
            NPC_JR:  t = jr_addr;
            NPC_J:   t = j_addr;
            default: t = beq_addr;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus: one outstanding read, req/gnt then rvalid.
interface if_fetch_stage_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding reads and
// feeds decode with held/bubbled instructions and single-delay-slot redirects.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
    input  logic                     clk,
    input  logic                     rst,
    if_fetch_stage_if.master         imem,
    input  logic                     stall_id,
    input  logic                     redirect_id,
    input  logic [1:0]               npc_sel_id,
    input  logic [31:0]              beq_bne_addr_id,
    input  logic [31:0]              jr_addr_id,
    input  logic [31:0]              jal_j_addr_id,
    output logic [31:0]              instr_r,
    output logic [31:0]              pc_plus_1_if_r,
    output logic                     instr_valid_if_r
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [1:0]  state_q,      state_d;
    logic [31:0] fetch_pc_q,   fetch_pc_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_pc_q,   redir_pc_d;
    logic [31:0] buf_instr_q,  buf_instr_d;
    logic [31:0] buf_pc4_q,    buf_pc4_d;
    logic [31:0] instr_q,      instr_d;
    logic [31:0] pc4_q,        pc4_d;
    logic        valid_q,      valid_d;

    logic [31:0] target;
    logic [31:0] fetch_pc4;
    logic [31:0] next_pc;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc4;

    assign target    = sel_target(npc_sel_id, beq_bne_addr_id, jr_addr_id, jal_j_addr_id) & ALIGN_MASK;
    assign fetch_pc4 = fetch_pc_q + 32'd4;

    // A redirect arriving together with the delay-slot delivery is used directly.
    assign next_pc = redirect_id  ? target     :
                     redir_pend_q ? redir_pc_q : fetch_pc4;

    assign deliver = ((state_q == ST_WAIT) && imem.rvalid && !stall_id) ||
                     ((state_q == ST_HOLD) && !stall_id);

    assign deliver_instr = (state_q == ST_HOLD) ? buf_instr_q : imem.rdata;
    assign deliver_pc4   = (state_q == ST_HOLD) ? buf_pc4_q   : fetch_pc4;

    assign imem.req  = (state_q == ST_FETCH) && !rst;
    assign imem.addr = fetch_pc_q;

    assign instr_r          = instr_q;
    assign pc_plus_1_if_r   = pc4_q;
    assign instr_valid_if_r = valid_q;

    // Next-state logic for the FSM, PC, redirect latch, skid buffer and decode outputs.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        buf_instr_d  = buf_instr_q;
        buf_pc4_d    = buf_pc4_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;

        if (redirect_id) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = target;
        end else begin
            redir_pend_d = redir_pend_q;
        end

        case (state_q)
            ST_FETCH: begin
                if (imem.gnt) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (imem.rvalid && stall_id) begin
                    buf_instr_d = imem.rdata;
                    buf_pc4_d   = fetch_pc4;
                    state_d     = ST_HOLD;
                end else if (imem.rvalid) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (!stall_id) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Stall freezes the decode-facing registers; otherwise deliver or bubble.
        if (deliver) begin
            instr_d      = deliver_instr;
            pc4_d        = deliver_pc4;
            valid_d      = 1'b1;
            fetch_pc_d   = next_pc & ALIGN_MASK;
            redir_pend_d = 1'b0;
        end else if (!stall_id) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            instr_d = instr_q;
            valid_d = valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            fetch_pc_q   <= RESET_PC & ALIGN_MASK;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= 32'h0000_0000;
            buf_instr_q  <= NOP_INSTR;
            buf_pc4_q    <= 32'h0000_0000;
            instr_q      <= NOP_INSTR;
            pc4_q        <= 32'h0000_0000;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc4_q    <= buf_pc4_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage: handshake, stall/hold,
// delay-slot redirects, PC wrap and reset in the middle of a transaction.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall_id;
    logic        redirect_id;
    logic [1:0]  npc_sel_id;
    logic [31:0] beq_bne_addr_id;
    logic [31:0] jr_addr_id;
    logic [31:0] jal_j_addr_id;
    logic [31:0] instr_r;
    logic [31:0] pc_plus_1_if_r;
    logic        instr_valid_if_r;

    int checks = 0;
    int errors = 0;

    if_fetch_stage_if imem ();

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem             (imem),
        .stall_id         (stall_id),
        .redirect_id      (redirect_id),
        .npc_sel_id       (npc_sel_id),
        .beq_bne_addr_id  (beq_bne_addr_id),
        .jr_addr_id       (jr_addr_id),
        .jal_j_addr_id    (jal_j_addr_id),
        .instr_r          (instr_r),
        .pc_plus_1_if_r   (pc_plus_1_if_r),
        .instr_valid_if_r (instr_valid_if_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode must never redirect while stalled.
    always @(posedge clk) begin
        if (redirect_id === 1'b1 && stall_id === 1'b1) begin
            errors++;
            $display("FAIL redirect_under_stall: redirect_id=1 stall_id=1 required not both");
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: one request granted immediately, response on the next cycle.
    task automatic fetch_one(input logic [31:0] data);
        imem.gnt = 1'b1;
        step();
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata  = data;
        step();
        imem.rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL rst_req_during: got %b want 0", imem.req); end
        step();
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL rst_req_held: got %b want 0", imem.req); end
        checks++; if (instr_r !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", instr_r, NOP); end
        checks++; if (pc_plus_1_if_r !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h want 0", pc_plus_1_if_r); end
        checks++; if (instr_valid_if_r !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid_if_r); end
        rst = 1'b0;
        #1;
        checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL post_rst_req: got %b want 1", imem.req); end
        checks++; if (imem.addr !== 32'h0) begin errors++; $display("FAIL post_rst_addr: got %h want 0", imem.addr); end
    endtask

    task automatic test_basic_fetch();
        imem.gnt = 1'b1;
        step();
        imem.gnt = 1'b0;
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL basic_wait_req: got %b want 0", imem.req); end
        checks++; if (instr_valid_if_r !== 1'b0) begin errors++; $display("FAIL basic_wait_valid: got %b want 0", instr_valid_if_r); end
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h2008_0005;
        step();
        imem.rvalid = 1'b0;
        checks++; if (instr_r !== 32'h2008_0005) begin errors++; $display("FAIL basic_instr: got %h want 20080005", instr_r); end
        checks++; if (pc_plus_1_if_r !== 32'h4) begin errors++; $display("FAIL basic_pc4: got %h want 4", pc_plus_1_if_r); end
        checks++; if (instr_valid_if_r !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", instr_valid_if_r); end
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin errors++; $display("FAIL basic_next_req: got req=%b addr=%h want req=1 addr=4", imem.req, imem.addr); end
    endtask

    task automatic test_gnt_delay();
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin errors++; $display("FAIL gnt_delay_req[%0d]: got req=%b addr=%h want req=1 addr=4", i, imem.req, imem.addr); end
            if (i > 0) begin
                checks++; if (instr_r !== NOP || instr_valid_if_r !== 1'b0) begin errors++; $display("FAIL gnt_delay_bubble[%0d]: got instr=%h valid=%b want %h/0", i, instr_r, instr_valid_if_r, NOP); end
            end
            if (i < 3) step();
        end
        fetch_one(32'h2009_0001);
        checks++; if (instr_r !== 32'h2009_0001 || pc_plus_1_if_r !== 32'h8) begin errors++; $display("FAIL gnt_delay_out: got instr=%h pc4=%h want 20090001/8", instr_r, pc_plus_1_if_r); end
    endtask

    task automatic test_stall_hold();
        imem.gnt = 1'b1;
        step();
        imem.gnt    = 1'b0;
        stall_id    = 1'b1;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h0000_0020;
        step();
        imem.rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d]: got %b want 0", i, imem.req); end
            checks++; if (instr_r !== NOP || instr_valid_if_r !== 1'b0 || pc_plus_1_if_r !== 32'h8) begin errors++; $display("FAIL hold_outputs[%0d]: got instr=%h valid=%b pc4=%h want %h/0/8", i, instr_r, instr_valid_if_r, pc_plus_1_if_r, NOP); end
            step();
        end
        stall_id = 1'b0;
        step();
        checks++; if (instr_r !== 32'h0000_0020 || instr_valid_if_r !== 1'b1 || pc_plus_1_if_r !== 32'hC) begin errors++; $display("FAIL hold_release: got instr=%h valid=%b pc4=%h want 20/1/c", instr_r, instr_valid_if_r, pc_plus_1_if_r); end
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'hC) begin errors++; $display("FAIL hold_next_req: got req=%b addr=%h want 1/c", imem.req, imem.addr); end
    endtask

    task automatic test_redirect_wait();
        fetch_one(32'h1111_000C);
        fetch_one(32'h1111_0010);
        checks++; if (imem.addr !== 32'h14) begin errors++; $display("FAIL redir_pre_addr: got %h want 14", imem.addr); end
        imem.gnt = 1'b1;
        step();
        imem.gnt      = 1'b0;
        redirect_id   = 1'b1;
        npc_sel_id    = 2'd2;
        jal_j_addr_id = 32'h0040_0100;
        step();
        redirect_id = 1'b0;
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL redir_wait_req: got %b want 0", imem.req); end
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hAAAA_0014;
        step();
        imem.rvalid = 1'b0;
        checks++; if (instr_r !== 32'hAAAA_0014 || pc_plus_1_if_r !== 32'h18) begin errors++; $display("FAIL redir_delay_slot: got instr=%h pc4=%h want aaaa0014/18", instr_r, pc_plus_1_if_r); end
        checks++; if (imem.addr !== 32'h0040_0100) begin errors++; $display("FAIL redir_target: got %h want 00400100", imem.addr); end
    endtask

    task automatic test_redirect_coincide();
        imem.gnt = 1'b1;
        step();
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hBBBB_0100;
        redirect_id = 1'b1;
        npc_sel_id  = 2'd1;
        jr_addr_id  = 32'h0000_0200;
        step();
        imem.rvalid = 1'b0;
        redirect_id = 1'b0;
        checks++; if (pc_plus_1_if_r !== 32'h0040_0104) begin errors++; $display("FAIL coincide_pc4: got %h want 00400104", pc_plus_1_if_r); end
        checks++; if (imem.addr !== 32'h200) begin errors++; $display("FAIL coincide_addr: got %h want 200", imem.addr); end
        // Reserved select 3 behaves as the branch target; redirect during FETCH.
        redirect_id     = 1'b1;
        npc_sel_id      = 2'd3;
        beq_bne_addr_id = 32'h0000_0300;
        jr_addr_id      = 32'h0000_0999;
        jal_j_addr_id   = 32'h0000_0888;
        step();
        redirect_id = 1'b0;
        checks++; if (imem.addr !== 32'h200) begin errors++; $display("FAIL sel3_slot_addr: got %h want 200", imem.addr); end
        fetch_one(32'hCCCC_0200);
        checks++; if (pc_plus_1_if_r !== 32'h204 || imem.addr !== 32'h300) begin errors++; $display("FAIL sel3_target: got pc4=%h addr=%h want 204/300", pc_plus_1_if_r, imem.addr); end
    endtask

    task automatic test_wrap();
        imem.gnt = 1'b1;
        step();
        imem.gnt      = 1'b0;
        imem.rvalid   = 1'b1;
        imem.rdata    = 32'hDDDD_0300;
        redirect_id   = 1'b1;
        npc_sel_id    = 2'd2;
        jal_j_addr_id = 32'hFFFF_FFFC;
        step();
        imem.rvalid = 1'b0;
        redirect_id = 1'b0;
        checks++; if (imem.addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_addr: got %h want fffffffc", imem.addr); end
        fetch_one(32'h1234_5678);
        checks++; if (pc_plus_1_if_r !== 32'h0 || instr_r !== 32'h1234_5678) begin errors++; $display("FAIL wrap_pc4: got pc4=%h instr=%h want 0/12345678", pc_plus_1_if_r, instr_r); end
        checks++; if (imem.addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got %h want 0", imem.addr); end
    endtask

    task automatic test_reset_mid();
        fetch_one(32'h0000_0001);
        imem.gnt = 1'b1;
        step();
        imem.gnt = 1'b0;
        checks++; if (imem.req !== 1'b0 || imem.addr !== 32'h4) begin errors++; $display("FAIL midrst_wait: got req=%b addr=%h want 0/4", imem.req, imem.addr); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin errors++; $display("FAIL midrst_req: got req=%b addr=%h want 1/0", imem.req, imem.addr); end
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hDEAD_BEEF;
        step();
        imem.rvalid = 1'b0;
        checks++; if (instr_r !== NOP || instr_valid_if_r !== 1'b0) begin errors++; $display("FAIL midrst_stale: got instr=%h valid=%b want %h/0", instr_r, instr_valid_if_r, NOP); end
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin errors++; $display("FAIL midrst_stale_req: got req=%b addr=%h want 1/0", imem.req, imem.addr); end
        fetch_one(32'h0BAD_F00D);
        checks++; if (instr_r !== 32'h0BAD_F00D || pc_plus_1_if_r !== 32'h4 || instr_valid_if_r !== 1'b1) begin errors++; $display("FAIL midrst_first: got instr=%h pc4=%h valid=%b want 0badf00d/4/1", instr_r, pc_plus_1_if_r, instr_valid_if_r); end
    endtask

    initial begin
        rst             = 1'b1;
        stall_id        = 1'b0;
        redirect_id     = 1'b0;
        npc_sel_id      = 2'd0;
        beq_bne_addr_id = 32'h0;
        jr_addr_id      = 32'h0;
        jal_j_addr_id   = 32'h0;
        imem.gnt        = 1'b0;
        imem.rvalid     = 1'b0;
        imem.rdata      = 32'h0;
        test_reset();
        test_basic_fetch();
        test_gnt_delay();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_coincide();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage, directly upstream of the decode stage. It owns the architectural fetch PC and issues one-outstanding-request reads to the instruction memory over a req/gnt/rvalid handshake. It presents instr_r and pc_plus_1_if_r to decode, holding them under stall and inserting NOP bubbles while memory is slow. It applies branch/jump redirects from decode with MIPS single-delay-slot semantics.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset (word aligned)
NOP_INSTR, 32'h0000_0000, bubble encoding (sll r0,r0,0)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  request valid
imem_addr  output  32  request byte address; bits[1:0] always 0
imem_gnt  input  1  request accepted this cycle (only meaningful while imem_req)
imem_rvalid  input  1  read data valid; at most one per granted request, at least 1 cycle after gnt
imem_rdata  input  32  instruction word
stall_id  input  1  decode cannot accept; hold outputs
redirect_id  input  1  one-cycle pulse: decode resolved a taken branch/jump
npc_sel_id  input  2  target select: 0 beq/bne, 1 jr, 2 j/jal, 3 reserved (treat as 0)
beq_bne_addr_id  input  32  branch target
jr_addr_id  input  32  register target
jal_j_addr_id  input  32  jump target
instr_r  output  32  instruction to decode (registered)
pc_plus_1_if_r  output  32  fetch address of instr_r plus 4 (registered)
instr_valid_if_r  output  1  instr_r holds a real instruction (registered)

Behaviour:
- Reset: state FETCH, fetch_pc=RESET_PC, redir_pend=0, buffer empty, instr_r=NOP_INSTR, pc_plus_1_if_r=0, instr_valid_if_r=0, imem_req=0 during the reset cycle.
- FSM states: FETCH, WAIT, HOLD.
- FETCH: imem_req=1, imem_addr=fetch_pc; req and addr held stable until gnt. On gnt -> WAIT.
- WAIT: imem_req=0. On rvalid:
  - stall_id=0: instr_r<=rdata, pc_plus_1_if_r<=fetch_pc+4, valid<=1; fetch_pc<=next_pc; -> FETCH.
  - stall_id=1: rdata and fetch_pc+4 captured into the 1-entry buffer -> HOLD. fetch_pc is not advanced.
- HOLD: no request. On the first cycle with stall_id=0, the buffer is loaded into the outputs, fetch_pc<=next_pc, -> FETCH.
- next_pc = redir_pc if redir_pend, else fetch_pc+4 (modulo 2^32; wraps 32'hFFFF_FFFC -> 0). redir_pend is cleared when consumed.
- Redirect: on redirect_id, redir_pc<=target selected by npc_sel_id and redir_pend<=1. The fetch outstanding or in progress at that moment is the delay slot: it is kept and delivered, and only the following fetch uses the target. If the delay-slot response arrives in the same cycle as redirect_id, the target is used directly as next_pc. A second redirect before consumption overwrites the first.
- redirect_id is legal only while stall_id=0; the bench asserts this.
- Bubbles: in any cycle with stall_id=0 and no instruction delivered, instr_r<=NOP_INSTR, valid<=0, and pc_plus_1_if_r holds.
- Stall: while stall_id=1, instr_r, pc_plus_1_if_r and instr_valid_if_r hold their values, whatever the FSM state.
- Best-case throughput is one instruction per two cycles (req/gnt, then rvalid). The outputs are never combinationally dependent on imem_* inputs.
- Reset mid-transaction: all state is discarded. A stale rvalid that arrives after reset, with no granted request outstanding, is ignored.
- imem_addr is fetch_pc even when imem_req=0.

Decomposition:
- Shared package (cpu_pkg): NPC_BEQ/NPC_JR/NPC_J encodings for npc_sel, NOP_INSTR, and the FSM state constants for FETCH/WAIT/HOLD.
- No sub-module is required. The next-PC select is small enough to inline; optionally it can be split out as npc_mux for reuse by pc_gen.

Test Plan:
- Reset, then gnt same cycle, rvalid next cycle with rdata=32'h2008_0005 -> imem_addr=0 first; instr_r=32'h2008_0005, pc_plus_1_if_r=4, valid=1; next request address is 4.
- gnt withheld 3 cycles -> imem_req/addr stable for 4 cycles; instr_r=NOP_INSTR, valid=0 throughout.
- stall_id high when rvalid returns 32'h0000_0020 -> outputs unchanged; HOLD with no request. stall drops -> instr_r=32'h0000_0020 next edge, then request at +4.
- redirect_id with npc_sel=2, jal_j_addr_id=32'h0040_0100, while fetch of 0x14 is in WAIT -> 0x14 is delivered (pc_plus_1=0x18); the next imem_addr is 0x0040_0100.
- redirect coinciding with rvalid (npc_sel=1, jr_addr_id=32'h0000_0200) -> the next request is at 0x200, not pc+4.
- fetch_pc=32'hFFFF_FFFC completes -> pc_plus_1_if_r=0 and the next imem_addr is 0; rst asserted in WAIT, then a late rvalid arrives -> the late rvalid is ignored and the first post-reset request is at RESET_PC.
